load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage block that consumes the memory-control outputs of the decode/control stage (`mem_read`, `mem_write`, byte mask, funct3) together with the ALU-computed address and rs2 store data. It performs one data-memory access at a time over a req/gnt/rvalid bus and stalls the pipeline while the access is outstanding. It aligns store bytes and enables, and sign- or zero-extends load data for writeback. Misaligned or unsupported accesses raise a fault instead of touching memory.

## Interface
- `XLEN`, 32, data and address width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock; synchronous, active-low.
- `req_valid_i`  in  1  memory-stage instruction present.
- `mem_read_i`  in  1  load request (from control unit).
- `mem_write_i`  in  1  store request.
- `mem_write_mask_i`  in  4  unshifted store mask: 0001 SB, 0011 SH, 1111 SW.
- `funct3_i`  in  3  access size/sign.
- `addr_i`  in  XLEN  effective byte address.
- `store_data_i`  in  XLEN  rs2 value.
- `stall_o`  out  1  hold upstream stages.
- `load_valid_o`  out  1  `load_data_o` valid (one cycle).
- `load_data_o`  out  XLEN  extended load result.
- `access_fault_o`  out  1  misaligned/illegal access (one cycle).
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  XLEN  word address, `[1:0]` = 0.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  XLEN  write data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  XLEN  read data.

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **IDLE, no request:** stays in IDLE when `req_valid_i` is low, or when both `mem_read_i` and `mem_write_i` are low.
- **IDLE, accepting a request:** latches the access and goes to REQ. The access is faulty if any of these hold:
  - `mem_read_i` and `mem_write_i` are both high.
  - A halfword access has `addr[0]` set.
  - A word access has `addr[1:0]` ≠ 0.
  - A load funct3 is not one of 000/001/010/100/101.
  - A store funct3 is not one of 000/001/010.
- **IDLE, faulty request:** no bus access; goes directly to DONE.
- **REQ:** `dmem_req_o`=1, with address/we/be/wdata held stable until `dmem_gnt_i`. On grant, a store goes to DONE and a load goes to WAIT.
- **WAIT:** `dmem_rvalid_i` is sampled only in this state. On rvalid, capture the extended data and go to DONE.
- **DONE:** one cycle, then IDLE.
  - `load_valid_o`=1 for a successful load.
  - `access_fault_o`=1 for a faulted access.
  - `req_valid_i` is ignored, because it still carries the completing instruction.
- **`stall_o` (combinational):** high when any of these hold:
  - IDLE with a valid memory request, faulted or not.
  - State is REQ.
  - State is WAIT.
- **Store formatting:**
  - `dmem_be_o` = `mem_write_mask_i` << `addr[1:0]`.
  - `dmem_wdata_o`: SB replicates the byte ×4, SH replicates the halfword ×2, SW passes through.
- **Loads:** `dmem_be_o`=1111.
- **Load extraction:** shift `rdata` right by 8·`addr[1:0]`, then:
  - LB: sign-extend bit 7.
  - LBU: zero-extend bit 7.
  - LH: sign-extend bit 15.
  - LHU: zero-extend bit 15.
  - LW: pass through.
- **Address:** `dmem_addr_o` = {`addr[XLEN-1:2]`, 2'b00}.
- **`load_data_o`:** holds its last value until the next load completes.

## Timing
- **Reset values:** all registered outputs are 0, state is IDLE. `stall_o` is forced to 0 while `rst_ni` is low.
- **Reset mid-operation:** aborts to IDLE with `dmem_req_o` dropped. A stale `dmem_rvalid_i` arriving in IDLE is ignored.
- **Store latency:** accept at cycle 0, REQ at cycle 1; with gnt at cycle 1, DONE is cycle 2 (`stall_o` high in cycles 0–1).
- **Load latency:** gnt at cycle 1, rvalid at cycle 2 (WAIT), DONE with `load_valid_o` at cycle 3.
- **Bus rule:** rvalid arrives no earlier than the cycle after gnt. Each cycle without gnt or rvalid extends REQ or WAIT by one cycle.
- **Fault latency:** accept at cycle 0, DONE with `access_fault_o` at cycle 1. `dmem_req_o` never rises.
- **Back-to-back:** a new request can be accepted no earlier than the cycle after DONE.

## Structure
- **`riscv_pkg`:** add the funct3 load/store constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
- **`lsu_state_e`:** new enum for the state machine, also placed in `riscv_pkg`.
- **Sub-module `load_extender`:** combinational, taking `rdata`, `addr[1:0]` and funct3 and producing the extended load result.

## Test plan
- **SB:** `addr`=0x1003, `data`=0x000000AB, gnt immediate → `dmem_addr_o`=0x1000, `be`=1000, `wdata`=0xABABABAB, DONE at cycle 2.
- **LB/LBU:** `addr`=0x2001, `rdata`=0x1234_80FF.
  - LB → `load_data_o`=0xFFFFFF80.
  - LBU → 0x00000080.
  - `load_valid_o` at cycle 3.
- **LH with delays:** `addr`=0x2002, gnt delayed 3 cycles, rvalid delayed 2 → `stall_o` held throughout, `load_data_o`=0x00001234 sign-extended correctly.
- **Misaligned LW:** LW at 0x3002 → no `dmem_req_o`, `access_fault_o`=1 at cycle 1, `load_valid_o`=0.
- **Reset mid-access:** `rst_ni` low during WAIT, then a late rvalid → IDLE, all outputs 0, no `load_valid_o`.
- **Back-to-back:** SW then LW with gnt and rvalid always high → second access accepted the cycle after the first DONE; no request accepted during DONE.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 definitions for the memory stage:
//   - funct3 encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - lsu_state_e, the load/store unit state machine encoding
//   - lsu_fault(), which classifies an access as misaligned or illegal
// ----------------------------------------------------------------------------
package riscv_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size as carried in funct3[1:0]
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  // An access faults when it is both a load and a store, uses a funct3 that
  // the operation does not define, or is not naturally aligned to its size.
  function automatic logic lsu_fault(
    input logic       mem_read,
    input logic       mem_write,
    input logic [2:0] funct3,
    input logic [1:0] offset
  );
    logic bad_funct3;
    logic misaligned;

    bad_funct3 = 1'b0;
    if (mem_read) begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad_funct3 = 1'b0;
        default:                             bad_funct3 = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: bad_funct3 = 1'b0;
        default:             bad_funct3 = 1'b1;
      endcase
    end

    case (funct3[1:0])
      SIZE_HALF: misaligned = offset[0];
      SIZE_WORD: misaligned = (offset != 2'b00);
      default:   misaligned = 1'b0;
    endcase

    return (mem_read && mem_write) || bad_funct3 || misaligned;
  endfunction

endpackage

// File: rtl/load_extender.sv
// ----------------------------------------------------------------------------
// load_extender
// Combinational load-data formatter. Brings the addressed byte/halfword of a
// full bus word down to bit 0 and sign- or zero-extends it by funct3.
// Ports:
//   rdata   in  XLEN  raw word returned by data memory
//   offset  in  2     byte offset of the access within the word
//   funct3  in  3     load size/sign (LB/LH/LW/LBU/LHU)
//   data    out XLEN  extended load result
// ----------------------------------------------------------------------------
module load_extender
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  // Right shift by 8 * offset places the addressed lane at bit 0.
  assign shifted = rdata >> {offset, 3'b000};

  // NOTE: data gets a default before the case so that every path assigns
  // it; an unassigned path in always_comb would infer a latch.
  always_comb begin
    data = shifted;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LBU:  data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-stage unit. Accepts one load or store at a time from the control
// stage, runs it over a req/gnt/rvalid data bus and stalls upstream until
// the access has been issued and, for loads, answered. Faulty accesses
// (misaligned, illegal funct3, load+store together) never reach the bus.
// Ports:
//   clk_i, rst_ni        clock; synchronous active-low reset
//   req_valid_i          memory-stage instruction present
//   mem_read_i           load request
//   mem_write_i          store request
//   mem_write_mask_i     unshifted store mask (0001 SB, 0011 SH, 1111 SW)
//   funct3_i             access size/sign
//   addr_i               effective byte address
//   store_data_i         rs2 store value
//   stall_o              hold upstream stages
//   load_valid_o         one-cycle pulse, load_data_o holds a new result
//   load_data_o          extended load result (held until next load)
//   access_fault_o       one-cycle pulse for a faulted access
//   dmem_req_o/we_o/addr_o/be_o/wdata_o   bus request side
//   dmem_gnt_i/rvalid_i/rdata_i           bus response side
// ----------------------------------------------------------------------------
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [3:0]      mem_write_mask_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            stall_o,
  output logic            load_valid_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            access_fault_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  lsu_state_e state_q, state_d;

  // Access captured when a request is accepted in IDLE
  logic            is_load_q;
  logic            we_q;
  logic            fault_q;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] load_data_q;

  logic            mem_req;
  logic            req_fault;
  logic            accept;
  logic [3:0]      store_be;
  logic [XLEN-1:0] store_wdata;
  logic [XLEN-1:0] ext_data;

  assign mem_req   = req_valid_i && (mem_read_i || mem_write_i);
  assign req_fault = lsu_fault(mem_read_i, mem_write_i, funct3_i, addr_i[1:0]);

  // Store lane enables follow the byte offset; the 4-bit result drops any
  // bits shifted past lane 3 (only possible for an access that faults).
  assign store_be = mem_write_mask_i << addr_i[1:0];

  // Narrow stores are replicated across the word so the selected lanes
  // carry the data whatever the offset.
  always_comb begin
    store_wdata = store_data_i;
    case (funct3_i[1:0])
      SIZE_BYTE: store_wdata = {(XLEN/8){store_data_i[7:0]}};
      SIZE_HALF: store_wdata = {(XLEN/16){store_data_i[15:0]}};
      default:   store_wdata = store_data_i;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (mem_req) begin
          accept  = 1'b1;
          state_d = req_fault ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (dmem_gnt_i) begin
          state_d = we_q ? LSU_DONE : LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = LSU_DONE;
        end
      end
      // DONE lasts one cycle; req_valid_i still belongs to the completing
      // instruction here, so it must not be accepted again.
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= LSU_IDLE;
      is_load_q   <= 1'b0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_load_q <= mem_read_i;
        we_q      <= mem_write_i;
        fault_q   <= req_fault;
        funct3_q  <= funct3_i;
        offset_q  <= addr_i[1:0];
        addr_q    <= {addr_i[XLEN-1:2], 2'b00};
        be_q      <= mem_read_i ? 4'b1111 : store_be;
        wdata_q   <= store_wdata;
      end
      // rvalid is only meaningful while a load is outstanding; a late
      // response after a reset abort lands in IDLE and is dropped.
      if (state_q == LSU_WAIT && dmem_rvalid_i) begin
        load_data_q <= ext_data;
      end
    end
  end

  load_extender #(
    .XLEN(XLEN)
  ) u_load_extender (
    .rdata  (dmem_rdata_i),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  // Bus side: request fields come straight from the captured access, so
  // they are stable for as long as REQ waits for a grant.
  assign dmem_req_o   = (state_q == LSU_REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  // Pipeline side
  assign load_valid_o   = (state_q == LSU_DONE) && is_load_q && !fault_q;
  assign access_fault_o = (state_q == LSU_DONE) && fault_q;
  assign load_data_o    = load_data_q;

  // Stall covers the accept cycle too, so the instruction stays put while
  // it is being captured; it is forced low while reset is asserted.
  assign stall_o = rst_ni &&
                   (((state_q == LSU_IDLE) && mem_req) ||
                    (state_q == LSU_REQ) ||
                    (state_q == LSU_WAIT));

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: a table of directed accesses,
// hand-written back-to-back and reset-abort sequences, and randomized
// accesses compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mask;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        access_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_ldata;

  load_store_unit #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .mem_read_i       (mem_read),
    .mem_write_i      (mem_write),
    .mem_write_mask_i (mask),
    .funct3_i         (funct3),
    .addr_i           (addr),
    .store_data_i     (sdata),
    .stall_o          (stall),
    .load_valid_o     (load_valid),
    .load_data_o      (load_data),
    .access_fault_o   (access_fault),
    .dmem_req_o       (dmem_req),
    .dmem_we_o        (dmem_we),
    .dmem_addr_o      (dmem_addr),
    .dmem_be_o        (dmem_be),
    .dmem_wdata_o     (dmem_wdata),
    .dmem_gnt_i       (gnt),
    .dmem_rvalid_i    (rvalid),
    .dmem_rdata_i     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  mask;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    int          lat;
    logic        fault;
    logic        valid;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ldata;
  } vec_t;

  typedef struct {
    int          lat;
    logic        c0_stall;
    logic        saw_req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        lv;
    logic        flt;
    logic [31:0] ldata;
    logic        early;
    logic        unstable;
    logic        timeout;
  } res_t;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [3:0] m, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] sd, input int g, input int r,
    input logic [31:0] rdv, input int lat, input logic flt, input logic vld,
    input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ew,
    input logic [31:0] el);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mask = m; v.f3 = f3; v.addr = a; v.sdata = sd;
    v.gnt_dly = g; v.rv_dly = r; v.rdata = rdv; v.lat = lat; v.fault = flt;
    v.valid = vld; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ew;
    v.exp_ldata = el;
    return v;
  endfunction

  // Reference model, derived from the access rules with plain arithmetic.
  function automatic vec_t model(input vec_t s);
    vec_t e;
    int   off;
    int   size;
    int   f3;
    int   b[4];
    int   val;
    logic legal;
    logic misaligned;
    e    = s;
    off  = int'(s.addr % 4);
    f3   = int'(s.f3);
    size = f3 % 4;
    if (s.rd) legal = (f3 inside {0, 1, 2, 4, 5});
    else      legal = (f3 < 3);
    misaligned = (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
    e.fault     = (s.rd && s.wr) || !legal || misaligned;
    e.valid     = 1'b0;
    e.exp_addr  = s.addr - (s.addr % 4);
    e.exp_be    = 4'b0000;
    e.exp_wdata = 32'h0;
    e.exp_ldata = 32'h0;
    if (e.fault) begin
      e.lat = 1;
    end else if (s.wr) begin
      e.lat    = 2 + s.gnt_dly;
      e.exp_be = 4'((int'(s.mask) << off) % 16);
      if (size == 0)      e.exp_wdata = (s.sdata % 256) * 32'h01010101;
      else if (size == 1) e.exp_wdata = (s.sdata % 65536) * 32'h00010001;
      else                e.exp_wdata = s.sdata;
    end else begin
      e.lat    = 3 + s.gnt_dly + s.rv_dly;
      e.valid  = 1'b1;
      e.exp_be = 4'b1111;
      for (int i = 0; i < 4; i++) b[i] = int'((s.rdata >> (8 * i)) % 256);
      case (f3)
        0: begin val = b[off]; if (val > 127) val = val - 256; end
        4: val = b[off];
        1: begin val = b[off] + 256 * b[off+1]; if (val > 32767) val = val - 65536; end
        5: val = b[off] + 256 * b[off+1];
        default: val = int'(s.rdata);
      endcase
      e.exp_ldata = 32'(val);
    end
    return e;
  endfunction

  // Issues one access and plays the memory side with the given delays.
  task automatic run_access(input vec_t v, output res_t r);
    int   gcnt;
    int   rcnt;
    logic in_wait;
    logic got_first;
    r = '{default: 0};
    r.timeout = 1'b1;
    gcnt = 0; rcnt = 0; in_wait = 1'b0; got_first = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; mask = v.mask;
    funct3 = v.f3; addr = v.addr; sdata = v.sdata;
    gnt = 1'b0; rvalid = 1'b0; rdata = ~v.rdata;
    #1;
    r.c0_stall = stall;
    if (dmem_req) r.saw_req = 1'b1;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(posedge clk); #1;
      if (!stall) begin
        r.lat = cyc; r.lv = load_valid; r.flt = access_fault; r.ldata = load_data;
        if (dmem_req) r.saw_req = 1'b1;
        r.timeout = 1'b0;
        break;
      end
      if (load_valid || access_fault) r.early = 1'b1;
      rvalid = 1'b0;
      rdata  = ~v.rdata;
      if (in_wait) begin
        if (rcnt == v.rv_dly) begin
          rvalid = 1'b1; rdata = v.rdata; in_wait = 1'b0;
        end else begin
          rcnt++;
        end
      end
      if (dmem_req) begin
        r.saw_req = 1'b1;
        if (!got_first) begin
          got_first = 1'b1;
          r.we = dmem_we; r.addr = dmem_addr; r.be = dmem_be; r.wdata = dmem_wdata;
        end else if (r.we !== dmem_we || r.addr !== dmem_addr ||
                     r.be !== dmem_be || r.wdata !== dmem_wdata) begin
          r.unstable = 1'b1;
        end
        if (gcnt == v.gnt_dly) begin
          gnt = 1'b1;
          if (!dmem_we) in_wait = 1'b1;
        end else begin
          gnt = 1'b0;
          gcnt++;
        end
      end else begin
        gnt = 1'b0;
      end
    end
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    gnt = 1'b0; rvalid = 1'b0;
  endtask

  task automatic check_access(input string tag, input vec_t v, input res_t r);
    check({tag, "_stall_c0"}, r.c0_stall, 1'b1);
    check({tag, "_timeout"}, r.timeout, 1'b0);
    check({tag, "_latency"}, r.lat, v.lat);
    check({tag, "_fault"}, r.flt, v.fault);
    check({tag, "_load_valid"}, r.lv, v.valid);
    check({tag, "_early_pulse"}, r.early, 1'b0);
    check({tag, "_bus_stable"}, r.unstable, 1'b0);
    if (v.fault) begin
      check({tag, "_no_req"}, r.saw_req, 1'b0);
    end else begin
      check({tag, "_req_seen"}, r.saw_req, 1'b1);
      check({tag, "_we"}, r.we, v.wr);
      check({tag, "_addr"}, r.addr, v.exp_addr);
      check({tag, "_be"}, r.be, v.exp_be);
      if (v.wr) check({tag, "_wdata"}, r.wdata, v.exp_wdata);
    end
    if (v.valid) last_ldata = v.exp_ldata;
    check({tag, "_load_data"}, r.ldata, last_ldata);
  endtask

  task automatic run_nop(input string tag);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; funct3 = 3'($urandom_range(0, 7));
    #1;
    check({tag, "_nop_stall"}, stall, 1'b0);
    @(posedge clk); #1;
    check({tag, "_nop_req"}, dmem_req, 1'b0);
    check({tag, "_nop_stall2"}, stall, 1'b0);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[16];
    vec_t        v;
    vec_t        s;
    res_t        r;
    int          kind;
    logic [2:0]  ld_f3s[5];
    logic [2:0]  st_f3s[3];

    ld_f3s[0] = 3'b000; ld_f3s[1] = 3'b001; ld_f3s[2] = 3'b010;
    ld_f3s[3] = 3'b100; ld_f3s[4] = 3'b101;
    st_f3s[0] = 3'b000; st_f3s[1] = 3'b001; st_f3s[2] = 3'b010;

    //            rd wr mask     f3      addr          sdata         g  r  rdata         lat flt vld exp_addr      be       wdata         ldata
    vecs[0]  = mk(0, 1, 4'b0001, 3'b000, 32'h00001003, 32'h000000AB, 0, 0, 32'h0,        2, 0, 0, 32'h00001000, 4'b1000, 32'hABABABAB, 32'h0);
    vecs[1]  = mk(1, 0, 4'b0000, 3'b000, 32'h00002001, 32'h0,        0, 0, 32'h123480FF, 3, 0, 1, 32'h00002000, 4'b1111, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(1, 0, 4'b0000, 3'b100, 32'h00002001, 32'h0,        0, 0, 32'h123480FF, 3, 0, 1, 32'h00002000, 4'b1111, 32'h0,        32'h00000080);
    vecs[3]  = mk(1, 0, 4'b0000, 3'b001, 32'h00002002, 32'h0,        3, 2, 32'h123480FF, 8, 0, 1, 32'h00002000, 4'b1111, 32'h0,        32'h00001234);
    vecs[4]  = mk(1, 0, 4'b0000, 3'b010, 32'h00003002, 32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[5]  = mk(0, 1, 4'b0011, 3'b001, 32'h00000102, 32'h0000BEEF, 1, 0, 32'h0,        3, 0, 0, 32'h00000100, 4'b1100, 32'hBEEFBEEF, 32'h0);
    vecs[6]  = mk(0, 1, 4'b1111, 3'b010, 32'h00000400, 32'hDEADBEEF, 0, 0, 32'h0,        2, 0, 0, 32'h00000400, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[7]  = mk(1, 0, 4'b0000, 3'b101, 32'h00000010, 32'h0,        0, 0, 32'h00008001, 3, 0, 1, 32'h00000010, 4'b1111, 32'h0,        32'h00008001);
    vecs[8]  = mk(1, 0, 4'b0000, 3'b001, 32'h00000010, 32'h0,        0, 0, 32'h00008001, 3, 0, 1, 32'h00000010, 4'b1111, 32'h0,        32'hFFFF8001);
    vecs[9]  = mk(1, 0, 4'b0000, 3'b010, 32'h00000020, 32'h0,        0, 1, 32'hCAFEF00D, 4, 0, 1, 32'h00000020, 4'b1111, 32'h0,        32'hCAFEF00D);
    vecs[10] = mk(1, 1, 4'b1111, 3'b010, 32'h00000040, 32'h12345678, 0, 0, 32'h0,        1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(1, 0, 4'b0000, 3'b011, 32'h00000000, 32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(0, 1, 4'b0001, 3'b100, 32'h00000000, 32'h000000FF, 0, 0, 32'h0,        1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[13] = mk(0, 1, 4'b0011, 3'b001, 32'h00000005, 32'h00001111, 0, 0, 32'h0,        1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[14] = mk(1, 0, 4'b0000, 3'b000, 32'h00000007, 32'h0,        0, 0, 32'h7F000000, 3, 0, 1, 32'h00000004, 4'b1111, 32'h0,        32'h0000007F);
    vecs[15] = mk(0, 1, 4'b0001, 3'b000, 32'h00000201, 32'h12345678, 2, 0, 32'h0,        4, 0, 0, 32'h00000200, 4'b0010, 32'h78787878, 32'h0);

    // Reset state, with a load request presented so the forced-low stall
    // is visible.
    rst_n = 1'b0; req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    mask = 4'b0000; funct3 = 3'b010; addr = 32'h0; sdata = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    last_ldata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", stall, 1'b0);
    check("reset_req", dmem_req, 1'b0);
    check("reset_load_valid", load_valid, 1'b0);
    check("reset_fault", access_fault, 1'b0);
    check("reset_load_data", load_data, 32'h0);
    check("reset_be", dmem_be, 4'b0000);
    check("reset_addr", dmem_addr, 32'h0);
    req_valid = 1'b0; mem_read = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_stall", stall, 1'b0);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_access(vecs[i], r);
      check_access($sformatf("vec%0d", i), vecs[i], r);
    end

    // Back-to-back SW then LW, gnt and rvalid tied high; the LW is already
    // presented during the SW's DONE cycle and must wait one more cycle.
    @(posedge clk); #1;
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'h11223344;
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mask = 4'b1111;
    funct3 = 3'b010; addr = 32'h00000080; sdata = 32'h55AA55AA;
    #1;
    check("b2b_c0_stall", stall, 1'b1);
    @(posedge clk); #1;
    check("b2b_c1_req", dmem_req, 1'b1);
    check("b2b_c1_we", dmem_we, 1'b1);
    check("b2b_c1_addr", dmem_addr, 32'h00000080);
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h00000084;
    #1;
    check("b2b_c2_done_stall", stall, 1'b0);
    check("b2b_c2_req", dmem_req, 1'b0);
    check("b2b_c2_lv", load_valid, 1'b0);
    check("b2b_c2_fault", access_fault, 1'b0);
    @(posedge clk); #1;
    check("b2b_c3_stall", stall, 1'b1);
    check("b2b_c3_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    check("b2b_c4_req", dmem_req, 1'b1);
    check("b2b_c4_addr", dmem_addr, 32'h00000084);
    check("b2b_c4_we", dmem_we, 1'b0);
    check("b2b_c4_be", dmem_be, 4'b1111);
    @(posedge clk); #1;
    check("b2b_c5_stall", stall, 1'b1);
    check("b2b_c5_lv", load_valid, 1'b0);
    @(posedge clk); #1;
    check("b2b_c6_lv", load_valid, 1'b1);
    check("b2b_c6_data", load_data, 32'h11223344);
    check("b2b_c6_stall", stall, 1'b0);
    last_ldata = 32'h11223344;
    req_valid = 1'b0; mem_read = 1'b0; gnt = 1'b0; rvalid = 1'b0;

    // Randomized accesses against the reference model
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 9) begin
        run_nop($sformatf("rnd%0d", i));
      end else begin
        s = vecs[0];
        s.rd = (kind < 4) || (kind == 8);
        s.wr = (kind >= 4);
        if ($urandom_range(0, 9) < 8) begin
          if (s.rd && !s.wr) s.f3 = ld_f3s[$urandom_range(0, 4)];
          else               s.f3 = st_f3s[$urandom_range(0, 2)];
        end else begin
          s.f3 = 3'($urandom_range(0, 7));
        end
        case (s.f3[1:0])
          2'b00:   s.mask = 4'b0001;
          2'b01:   s.mask = 4'b0011;
          default: s.mask = 4'b1111;
        endcase
        s.addr = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (s.f3[1:0] == 2'b01) s.addr[0] = 1'b0;
          if (s.f3[1:0] == 2'b10) s.addr[1:0] = 2'b00;
        end
        s.sdata   = $urandom;
        s.rdata   = $urandom;
        s.gnt_dly = $urandom_range(0, 3);
        s.rv_dly  = $urandom_range(0, 3);
        v = model(s);
        run_access(v, r);
        check_access($sformatf("rnd%0d", i), v, r);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    // Reset while a load waits for rvalid, followed by a stale rvalid
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    addr = 32'h00000040; gnt = 1'b0; rvalid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_req", dmem_req, 1'b1);
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    check("rst_mid_wait_stall", stall, 1'b1);
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
    #1;
    check("rst_mid_forced_stall", stall, 1'b0);
    @(posedge clk); #1;
    check("rst_mid_req_low", dmem_req, 1'b0);
    check("rst_mid_lv", load_valid, 1'b0);
    check("rst_mid_fault", access_fault, 1'b0);
    check("rst_mid_load_data", load_data, 32'h0);
    check("rst_mid_be", dmem_be, 4'b0000);
    check("rst_mid_addr", dmem_addr, 32'h0);
    check("rst_mid_wdata", dmem_wdata, 32'h0);
    check("rst_mid_we", dmem_we, 1'b0);
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD0001;
    @(posedge clk); #1;
    rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_late_lv%0d", k), load_valid, 1'b0);
      check($sformatf("rst_late_stall%0d", k), stall, 1'b0);
      check($sformatf("rst_late_data%0d", k), load_data, 32'h0);
      @(posedge clk); #1;
    end
    last_ldata = 32'h0;

    // Normal operation resumes after the abort
    run_access(vecs[8], r);
    check_access("post_rst", vecs[8], r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
